issue_slots: RTL and testbench
==============================

# issue_slots

Issue-queue slot storage for the out-of-order core: holds up to WIDTH pending micro-ops, presents the ready ones as a request vector to a `queue_arbiter`, and consumes the one-hot grant that comes back. Each cycle it can do three things:
- allocate one incoming op into the lowest free slot,
- mark slots ready on wakeup,
- issue the granted slot through a registered output and free that slot.

## Interface
- WIDTH, 4, number of slots; also the width of request, grant and wakeup vectors.
- DATA_W, 32, payload width per slot.

- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_wr_en  input  1  allocate request; accepted only when o_full=0.
- i_wr_data  input  DATA_W  payload of the op being allocated.
- i_wr_ready  input  1  op is ready at allocation.
- i_wake  input  WIDTH  per-slot wakeup; sets the ready bit of valid slots.
- o_full  output  1  all WIDTH slots valid.
- o_count  output  $clog2(WIDTH+1)  number of valid slots.
- o_request  output  WIDTH  valid & ready per slot; combinational from registers only; drives the arbiter's i_request.
- i_grant  input  WIDTH  one-hot or zero grant from the arbiter.
- o_issue_valid  output  1  registered; issued op present this cycle.
- o_issue_data  output  DATA_W  registered payload of the issued op.
- o_error  output  1  sticky illegal-grant flag (see Configuration).

## Operation
- Per-slot state: valid bit, ready bit, DATA_W payload.
- Allocation:
  - If i_wr_en=1 and o_full=0, the target is the lowest-index slot with valid=0, judged on the register state at the start of the cycle.
  - The target slot sets valid=1, payload=i_wr_data, and ready=i_wr_ready | i_wake[target].
  - A write while o_full=1 is dropped silently; no state changes.
- Wakeup: for each slot i, if i_wake[i]=1 and valid[i]=1, ready[i] is set to 1. Wakeup on an invalid slot that is not the allocation target is ignored.
- Issue:
  - If i_grant=1<<k and o_request[k]=1, slot k clears valid and ready.
  - o_issue_data takes payload[k] and o_issue_valid goes to 1, both on the next edge.
  - If i_grant=0, o_issue_valid goes to 0 on the next edge and o_issue_data holds its value.
- Simultaneous allocate and issue:
  - Both happen in the same cycle.
  - A slot freed by issue is not reusable until the following cycle.
  - When o_full=1 at the start of the cycle, the write is dropped even though a slot is being issued.
- o_count is the registered valid popcount, updated with +1 for a write, −1 for an issue, net 0 for both.
- Reset, applied at any time including mid-operation, clears:
  - all valid and ready bits,
  - o_issue_valid=0, o_issue_data=0, o_error=0, o_count=0.
  - Payloads of invalid slots are don't-care.
  - An i_wr_en or i_grant in the reset cycle is discarded.

## Timing
- Allocate at edge t: slot visible in o_count and o_full after edge t. It appears in o_request after edge t if it was written ready.
- Wakeup at edge t: o_request bit rises after edge t.
- Grant-to-issue latency is 1 cycle:
  - grant sampled at edge t,
  - o_issue_valid/o_issue_data valid after edge t,
  - o_request bit drops after edge t.
- No combinational path from i_grant, i_wr_*, or i_wake to any output.
- Back-to-back issue is allowed: one op per cycle.

## Configuration
- ISSUE_SLOTS_CHECK_EN defined:
  - A grant is illegal if it is non-one-hot and non-zero, or if it names a slot with o_request=0.
  - An illegal grant is ignored entirely: no slot freed, o_issue_valid=0 next cycle.
  - It also sets o_error=1 on the next edge, held until reset.
- ISSUE_SLOTS_CHECK_EN undefined:
  - o_error tied 0; no check logic is built.
  - An illegal grant gives unspecified o_issue_data and slot state, with no X-propagation requirement.
  - The arbiter is trusted.

## Test plan
- Reset then 4 writes (WIDTH=4, data 0xA0..0xA3, i_wr_ready=1) → slots 0..3 filled in order; o_request=4'b1111; o_full=1; o_count=4; 5th write (0xA4) dropped.
- Grant 4'b0100 with slots full → next cycle: o_issue_valid=1, o_issue_data=0xA2, o_request=4'b1011, o_count=3. The next write (0xB0) lands in slot 2.
- Same-cycle write (0xC0, i_wr_ready=0) and grant 4'b0001 with slots 0,1 valid → next cycle: 0xC0 in slot 2 (slot 0 not reused), issue 0xA0, o_count=2. i_wake=4'b0100 then raises o_request[2].
- i_wake on an empty slot, then allocation into that slot with i_wr_ready=0 → ready=0. Wake in the same cycle as allocation → ready=1.
- With ISSUE_SLOTS_CHECK_EN: grant 4'b0011, or a grant to a non-requesting slot → no slot freed, o_issue_valid=0, o_error=1 sticky; i_rst clears it to 0.
- Assert i_rst during a grant and write with 3 slots valid → next cycle all outputs 0 and o_request=0; the grant is not issued.

Source files
------------

// File: rtl/issue_slots_if.sv
// ---------------------------------------------------------------------------
// issue_slots_if
// Bundles the allocation, wakeup, arbiter and issue signals of the issue-queue
// slot storage so the core side and the slot block share one connection.
//
// Parameters:
//   WIDTH   number of slots; width of wake, request and grant vectors
//   DATA_W  payload width per slot
//
// Signals (direction as seen by the slot storage, i.e. the slave modport):
//   i_wr_en        in   allocate request
//   i_wr_data      in   payload of the op being allocated
//   i_wr_ready     in   op is ready at allocation
//   i_wake         in   per-slot wakeup
//   i_grant        in   one-hot or zero grant from the arbiter
//   o_full         out  all slots valid
//   o_count        out  number of valid slots
//   o_request      out  valid & ready per slot, towards the arbiter
//   o_issue_valid  out  issued op present this cycle
//   o_issue_data   out  payload of the issued op
//   o_error        out  sticky illegal-grant flag
//
// master: the core/arbiter side that drives requests and consumes outputs.
// slave:  the slot storage itself.
// ---------------------------------------------------------------------------
interface issue_slots_if #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic              i_wr_en;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_wr_ready;
    logic [WIDTH-1:0]  i_wake;
    logic [WIDTH-1:0]  i_grant;
    logic              o_full;
    logic [CNT_W-1:0]  o_count;
    logic [WIDTH-1:0]  o_request;
    logic              o_issue_valid;
    logic [DATA_W-1:0] o_issue_data;
    logic              o_error;

    modport master (
        output i_wr_en, i_wr_data, i_wr_ready, i_wake, i_grant,
        input  o_full, o_count, o_request, o_issue_valid, o_issue_data, o_error
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_wr_ready, i_wake, i_grant,
        output o_full, o_count, o_request, o_issue_valid, o_issue_data, o_error
    );
endinterface

// File: rtl/issue_slots.sv
// ---------------------------------------------------------------------------
// issue_slots
// Issue-queue slot storage. Holds up to WIDTH pending micro-ops, presents the
// ready ones as a request vector to the arbiter and consumes the one-hot grant.
// Each cycle it can allocate one op into the lowest free slot, wake slots up,
// and issue the granted slot through a registered output while freeing it.
//
// Ports:
//   i_clk   clock, all state changes on the rising edge
//   i_rst   synchronous active-high reset
//   bus     issue_slots_if.slave (allocation, wakeup, grant, issue, status)
//
// Optional build macro ISSUE_SLOTS_CHECK_EN:
//   defined   - illegal grants (multi-hot, or naming a non-requesting slot)
//               are ignored and raise a sticky o_error.
//   undefined - the arbiter is trusted, o_error is tied low.
// ---------------------------------------------------------------------------
module issue_slots #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 32
) (
    input logic         i_clk,
    input logic         i_rst,
    issue_slots_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  valid_q;
    logic [WIDTH-1:0]  ready_q;
    logic [DATA_W-1:0] payload_q [WIDTH];
    logic [CNT_W-1:0]  count_q;
    logic              issue_valid_q;
    logic [DATA_W-1:0] issue_data_q;

    logic              full;
    logic              do_alloc;
    logic              issue_fire;
    logic [WIDTH-1:0]  request;
    logic [WIDTH-1:0]  free_slots;
    logic [WIDTH-1:0]  alloc_sel;
    logic [WIDTH-1:0]  issue_sel;
    logic [WIDTH-1:0]  valid_n;
    logic [WIDTH-1:0]  ready_n;
    logic [DATA_W-1:0] issue_payload;

    assign request    = valid_q & ready_q;
    assign full       = &valid_q;
    assign free_slots = ~valid_q;
    assign do_alloc   = bus.i_wr_en & ~full;

    // Isolating the lowest set bit of the free vector picks the lowest free
    // slot. Freeing by issue only shows up in valid_q next cycle, so a slot
    // being issued now can never be chosen as the allocation target.
    assign alloc_sel = do_alloc ? (free_slots & (~free_slots + WIDTH'(1))) : '0;

`ifdef ISSUE_SLOTS_CHECK_EN
    logic grant_onehot;
    logic grant_illegal;
    logic error_q;

    assign grant_onehot  = (bus.i_grant != '0) &&
                           ((bus.i_grant & (bus.i_grant - WIDTH'(1))) == '0);
    assign grant_illegal = (bus.i_grant != '0) &&
                           (!grant_onehot || ((bus.i_grant & request) == '0));
    assign issue_sel     = grant_illegal ? '0 : bus.i_grant;

    // Sticky illegal-grant flag; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            error_q <= 1'b0;
        end else if (grant_illegal) begin
            error_q <= 1'b1;
        end
    end

    assign bus.o_error = error_q;
`else
    // Trusted arbiter: a grant only takes effect on a requesting slot.
    assign issue_sel   = bus.i_grant & request;
    assign bus.o_error = 1'b0;
`endif

    assign issue_fire = |issue_sel;

    // Select the payload of the granted slot with an AND-OR mux.
    always_comb begin
        issue_payload = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (issue_sel[i]) begin
                issue_payload = issue_payload | payload_q[i];
            end
        end
    end

    // Next valid/ready per slot: issue clears, wakeup sets ready on valid
    // slots, and the allocation target also honours a same-cycle wakeup.
    always_comb begin
        valid_n = '0;
        ready_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            valid_n[i] = (valid_q[i] & ~issue_sel[i]) | alloc_sel[i];
            ready_n[i] = ((ready_q[i] | (bus.i_wake[i] & valid_q[i])) & ~issue_sel[i]) |
                         (alloc_sel[i] & (bus.i_wr_ready | bus.i_wake[i]));
        end
    end

    // Slot flags, occupancy count and the registered issue port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q       <= '0;
            ready_q       <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else begin
            valid_q       <= valid_n;
            ready_q       <= ready_n;
            count_q       <= count_q + CNT_W'(do_alloc) - CNT_W'(issue_fire);
            issue_valid_q <= issue_fire;
            if (issue_fire) begin
                issue_data_q <= issue_payload;
            end
        end
    end

    // Payloads are don't-care while a slot is invalid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (alloc_sel[i] && !i_rst) begin
                payload_q[i] <= bus.i_wr_data;
            end
        end
    end

    assign bus.o_full        = full;
    assign bus.o_count       = count_q;
    assign bus.o_request     = request;
    assign bus.o_issue_valid = issue_valid_q;
    assign bus.o_issue_data  = issue_data_q;

endmodule

// File: tb/tb_issue_slots.sv
// ---------------------------------------------------------------------------
// tb_issue_slots
// Directed testbench for issue_slots (WIDTH=4, DATA_W=32). Expected issued
// payloads are queued when a grant is applied; a negedge monitor pops and
// compares them whenever o_issue_valid is high. Status outputs are compared
// directly one time unit after each rising edge.
// The illegal-grant section is only built when ISSUE_SLOTS_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_issue_slots;
    localparam int WIDTH  = 4;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    issue_slots_if #(.WIDTH(WIDTH), .DATA_W(DATA_W)) bus ();

    issue_slots #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every issued op must match the oldest queued one.
    always @(negedge clk) begin
        if (bus.o_issue_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_issue: got data 0x%0h, expected no issue", bus.o_issue_data);
            end else begin
                logic [DATA_W-1:0] exp;
                exp = exp_q.pop_front();
                if (bus.o_issue_data !== exp) begin
                    errors++;
                    $display("[TB] FAIL issue_data: got 0x%0h, expected 0x%0h", bus.o_issue_data, exp);
                end
            end
        end
    end

    // Compare one value and log a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Compare the status outputs seen after the last edge.
    task automatic checkState(input string tag, input logic [3:0] req, input int cnt,
                              input logic full, input logic ivalid);
        checkOutput({tag, "_request"}, 32'(bus.o_request), 32'(req));
        checkOutput({tag, "_count"}, 32'(bus.o_count), 32'(cnt));
        checkOutput({tag, "_full"}, 32'(bus.o_full), 32'(full));
        checkOutput({tag, "_issue_valid"}, 32'(bus.o_issue_valid), 32'(ivalid));
    endtask

    // Drive one cycle of inputs, clock it in, then return inputs to idle.
    task automatic applyStimulus(input logic wr_en, input logic [DATA_W-1:0] data,
                                 input logic wr_ready, input logic [3:0] wake,
                                 input logic [3:0] grant, input logic reset);
        rst            = reset;
        bus.i_wr_en    = wr_en;
        bus.i_wr_data  = data;
        bus.i_wr_ready = wr_ready;
        bus.i_wake     = wake;
        bus.i_grant    = grant;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.i_wr_en    = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_wr_ready = 1'b0;
        bus.i_wake     = '0;
        bus.i_grant    = '0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_wr_en    = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_wr_ready = 1'b0;
        bus.i_wake     = '0;
        bus.i_grant    = '0;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 1);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 1);
        checkState("reset", 4'b0000, 0, 0, 0);
        checkOutput("reset_issue_data", bus.o_issue_data, 32'h0);
        checkOutput("reset_error", 32'(bus.o_error), 32'h0);

        $display("[TB] fill four slots, then write while full");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'hA0 + 32'(i), 1, 4'b0000, 4'b0000, 0);
            checkOutput("fill_count", 32'(bus.o_count), 32'(i + 1));
        end
        checkState("full", 4'b1111, 4, 1, 0);
        applyStimulus(1, 32'hA4, 1, 4'b0000, 4'b0000, 0);
        checkState("drop", 4'b1111, 4, 1, 0);

        $display("[TB] issue slot 2, refill it, drain back-to-back");
        exp_q.push_back(32'hA2);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0100, 0);
        checkState("issue2", 4'b1011, 3, 0, 1);
        applyStimulus(1, 32'hB0, 1, 4'b0000, 4'b0000, 0);
        checkState("refill2", 4'b1111, 4, 1, 0);
        exp_q.push_back(32'hB0);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0100, 0);
        checkState("drain_b0", 4'b1011, 3, 0, 1);
        exp_q.push_back(32'hA0);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0001, 0);
        exp_q.push_back(32'hA1);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0010, 0);
        exp_q.push_back(32'hA3);
        applyStimulus(0, 0, 0, 4'b0000, 4'b1000, 0);
        checkState("drained", 4'b0000, 0, 0, 1);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 0);
        checkState("idle", 4'b0000, 0, 0, 0);
        checkOutput("hold_issue_data", bus.o_issue_data, 32'hA3);

        $display("[TB] same-cycle allocate and issue");
        applyStimulus(1, 32'hD0, 1, 4'b0000, 4'b0000, 0);
        applyStimulus(1, 32'hD1, 1, 4'b0000, 4'b0000, 0);
        exp_q.push_back(32'hD0);
        applyStimulus(1, 32'hC0, 0, 4'b0000, 4'b0001, 0);
        checkState("alloc_issue", 4'b0010, 2, 0, 1);
        applyStimulus(0, 0, 0, 4'b0100, 4'b0000, 0);
        checkState("wake_c0", 4'b0110, 2, 0, 0);
        exp_q.push_back(32'hC0);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0100, 0);
        checkState("issue_c0", 4'b0010, 1, 0, 1);
        exp_q.push_back(32'hD1);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0010, 0);
        checkState("issue_d1", 4'b0000, 0, 0, 1);

        $display("[TB] wakeup on empty slot and at allocation");
        applyStimulus(0, 0, 0, 4'b0001, 4'b0000, 0);
        checkState("wake_empty", 4'b0000, 0, 0, 0);
        applyStimulus(1, 32'hE0, 0, 4'b0000, 4'b0000, 0);
        checkState("alloc_notready", 4'b0000, 1, 0, 0);
        applyStimulus(1, 32'hE1, 0, 4'b0010, 4'b0000, 0);
        checkState("alloc_wake", 4'b0010, 2, 0, 0);
        exp_q.push_back(32'hE1);
        applyStimulus(0, 0, 0, 4'b0001, 4'b0010, 0);
        checkState("issue_e1_wake_e0", 4'b0001, 1, 0, 1);
        exp_q.push_back(32'hE0);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0001, 0);
        checkState("issue_e0", 4'b0000, 0, 0, 1);

`ifdef ISSUE_SLOTS_CHECK_EN
        $display("[TB] illegal grants");
        applyStimulus(1, 32'hF0, 1, 4'b0000, 4'b0000, 0);
        applyStimulus(1, 32'hF1, 1, 4'b0000, 4'b0000, 0);
        checkOutput("pre_illegal_error", 32'(bus.o_error), 32'h0);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0011, 0);
        checkState("multihot", 4'b0011, 2, 0, 0);
        checkOutput("multihot_error", 32'(bus.o_error), 32'h1);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0100, 0);
        checkState("nonrequest", 4'b0011, 2, 0, 0);
        checkOutput("nonrequest_error", 32'(bus.o_error), 32'h1);
        exp_q.push_back(32'hF0);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0001, 0);
        checkState("legal_after", 4'b0010, 1, 0, 1);
        checkOutput("sticky_error", 32'(bus.o_error), 32'h1);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 1);
        checkOutput("error_cleared", 32'(bus.o_error), 32'h0);
        checkState("check_reset", 4'b0000, 0, 0, 0);
`endif

        $display("[TB] reset during grant and write");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h60 + 32'(i), 1, 4'b0000, 4'b0000, 0);
        end
        exp_q.push_back(32'h63);
        applyStimulus(0, 0, 0, 4'b0000, 4'b1000, 0);
        checkState("pre_reset", 4'b0111, 3, 0, 1);
        applyStimulus(1, 32'h70, 1, 4'b0000, 4'b0001, 1);
        checkState("mid_reset", 4'b0000, 0, 0, 0);
        checkOutput("mid_reset_issue_data", bus.o_issue_data, 32'h0);
        checkOutput("mid_reset_error", 32'(bus.o_error), 32'h0);
        applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 0);
        checkState("post_reset", 4'b0000, 0, 0, 0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
